// File: rtl/store_monitor_if.sv
// Store bus from the processor plus the drain port of the monitor's store log.
// The master side drives stores and pops; the slave side is store_monitor.
interface store_monitor_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        log_pop;
  logic        log_valid;
  logic [31:0] log_adr;
  logic [31:0] log_data;

  modport master (
    output MemWrite, DataAdr, WriteData, log_pop,
    input  log_valid, log_adr, log_data
  );

  modport slave (
    input  MemWrite, DataAdr, WriteData, log_pop,
    output log_valid, log_adr, log_data
  );
endinterface

// File: rtl/store_monitor.sv
// End-of-program checker on the processor store bus: sticky pass/fail verdict with
// store/cycle counters and a first-word-fall-through log of accepted stores.
module store_monitor #(
  parameter int unsigned PASS_ADDR    = 32'd100,
  parameter int unsigned PASS_DATA    = 32'd25,
  parameter int unsigned SCRATCH_ADDR = 32'd96,
  parameter int unsigned TIMEOUT      = 32'd1000,
  parameter int unsigned LOG_DEPTH    = 32'd8,
  parameter int unsigned CNT_W        = 32'd16
) (
  input  logic             clk,
  input  logic             reset,
  store_monitor_if.slave   bus,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_code,
  output logic [CNT_W-1:0] store_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic             log_overflow
);

  localparam int unsigned PTR_W = $clog2(LOG_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 32'd1;

  typedef enum logic [1:0] {
    stRun  = 2'd0,
    stPass = 2'd1,
    stFail = 2'd2
  } stateT;

  stateT            state;
  stateT            nextState;
  logic [1:0]       nextFailCode;
  logic             sampleStore;
  logic             isPassAdr;
  logic             isTimeout;

  logic [63:0]      logMem [LOG_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] nextOcc;
  logic             logFull;
  logic             logEmpty;
  logic             logPopOk;
  logic             logPushOk;
  logic [63:0]      logHead;

  assign sampleStore = (state == stRun) && bus.MemWrite;
  assign isPassAdr   = (bus.DataAdr == PASS_ADDR);
  assign isTimeout   = (cycle_count == CNT_W'(TIMEOUT - 32'd1));

  // Verdict next-state: store classification outranks the timeout on the same edge.
  always_comb begin
    nextState    = state;
    nextFailCode = fail_code;
    case (state)
      stRun: begin
        if (sampleStore && isPassAdr && (bus.WriteData == PASS_DATA)) begin
          nextState = stPass;
        end else if (sampleStore && isPassAdr) begin
          nextState    = stFail;
          nextFailCode = 2'd1;
        end else if (sampleStore && (bus.DataAdr != SCRATCH_ADDR)) begin
          nextState    = stFail;
          nextFailCode = 2'd2;
        end else if (isTimeout) begin
          nextState    = stFail;
          nextFailCode = 2'd3;
        end else begin
          nextState = stRun;
        end
      end
      stPass:  nextState = stPass;
      stFail:  nextState = stFail;
      default: nextState = stFail;
    endcase
  end

  // Verdict register; done/pass are registered decodes of the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= stRun;
      fail_code <= 2'd0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state     <= nextState;
      fail_code <= nextFailCode;
      done      <= (nextState != stRun);
      pass      <= (nextState == stPass);
    end
  end

  // Counters run only in RUN; store_count saturates instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= {CNT_W{1'b0}};
      store_count <= {CNT_W{1'b0}};
    end else begin
      if (state == stRun) begin
        cycle_count <= cycle_count + CNT_W'(1);
      end
      if (sampleStore && (store_count != {CNT_W{1'b1}})) begin
        store_count <= store_count + CNT_W'(1);
      end
    end
  end

  assign logEmpty  = (occ == {OCC_W{1'b0}});
  assign logFull   = (occ == OCC_W'(LOG_DEPTH));
  assign logPopOk  = bus.log_pop && !logEmpty;
  assign logPushOk = sampleStore && (!logFull || logPopOk);

  // Occupancy update; a pop frees the slot a same-edge push needs when full.
  always_comb begin
    nextOcc = occ;
    case ({logPushOk, logPopOk})
      2'b10:   nextOcc = occ + OCC_W'(1);
      2'b01:   nextOcc = occ - OCC_W'(1);
      default: nextOcc = occ;
    endcase
  end

  // Log pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr         <= {PTR_W{1'b0}};
      rdPtr         <= {PTR_W{1'b0}};
      occ           <= {OCC_W{1'b0}};
      bus.log_valid <= 1'b0;
      log_overflow  <= 1'b0;
    end else begin
      if (logPushOk) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (logPopOk) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      occ           <= nextOcc;
      bus.log_valid <= (nextOcc != {OCC_W{1'b0}});
      if (sampleStore && logFull && !logPopOk) begin
        log_overflow <= 1'b1;
      end
    end
  end

  // Log storage; contents survive reset since only the pointers define validity.
  always_ff @(posedge clk) begin
    if (logPushOk) begin
      logMem[wrPtr] <= {bus.DataAdr, bus.WriteData};
    end
  end

  assign logHead      = logMem[rdPtr];
  assign bus.log_adr  = logEmpty ? 32'd0 : logHead[63:32];
  assign bus.log_data = logEmpty ? 32'd0 : logHead[31:0];

endmodule
